pc_seq_unit: RTL and testbench

//  Next-generation fetch PC sequencer: holds the fetch PC, selects next PC among

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_seq_unit_if.sv | 36 +++
 rtl/pc_seq_ras.sv | 48 ++++
 rtl/pc_seq_unit.sv | 107 ++++++++++
 tb/tb_pc_seq_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch PC sequencer: run/halt state, next-PC source
// select and the INC alignment mask helper.
package pc_seq_pkg;

  typedef enum logic {
    RUN,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_JR,
    SEL_EXC,
    SEL_RTI
  } sel_e;

  // Clears the address bits below log2(inc); callers truncate to their width.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Redirect/control inputs and PC outputs of the fetch PC sequencer.
// master = decode/execute redirect side, slave = pc_seq_unit.
interface pc_seq_unit_if #(
  parameter int unsigned AW = 16
);
  logic          stall;
  logic          br_valid;
  logic [AW-1:0] br_off;
  logic          jr_valid;
  logic [AW-1:0] rs;
  logic [AW-1:0] imm;
  logic          siic;
  logic          rti;
  logic          halt;
  logic          call;
  logic          ret;

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] epc;
  logic          halted;
  logic          exc_active;
  logic [AW-1:0] ras_top;
  logic          ras_valid;

  modport master (
    output stall, br_valid, br_off, jr_valid, rs, imm, siic, rti, halt, call, ret,
    input  pc, pc_next, pc_inc, epc, halted, exc_active, ras_top, ras_valid
  );

  modport slave (
    input  stall, br_valid, br_off, jr_valid, rs, imm, siic, rti, halt, call, ret,
    output pc, pc_next, pc_inc, epc, halted, exc_active, ras_top, ras_valid
  );
endinterface

// File: rtl/pc_seq_ras.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops on empty are ignored, push+pop together replaces the top entry.
module pc_seq_ras #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] data,
  output logic [AW-1:0] top,
  output logic          valid
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] ptr_up;
  logic [PW-1:0] ptr_dn;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign ptr_up = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign ptr_dn = (ptr == '0) ? PW'(DEPTH - 1) : ptr - 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop && count != '0) begin
      mem[ptr] <= data;
    end else if (push) begin
      ptr        <= ptr_up;
      mem[ptr_up] <= data;
      if (count != CW'(DEPTH)) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= ptr_dn;
      count <= count - 1'b1;
    end
  end

  assign valid = (count != '0);
  assign top   = valid ? mem[ptr] : '0;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch PC sequencer with branch/jump/exception/rti redirect, stall and sticky halt.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned INC       = 2,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned EXC_VEC   = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_seq_unit_if.slave   bus
);
  localparam logic [AW-1:0] MASK  = AW'(align_mask(INC));
  localparam logic [AW-1:0] INC_W = AW'(INC);

  state_e        state;
  sel_e          sel;
  logic [AW-1:0] pc;
  logic [AW-1:0] epc;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic          halted;
  logic          exc_active;

  assign pc_inc = pc + INC_W;

  // Priority: exception, halt, rti, jump (stallable), branch, stall, increment.
  always_comb begin
    sel = SEL_INC;
    if (state == HALT)                sel = SEL_HOLD;
    else if (bus.siic && !exc_active) sel = SEL_EXC;
    else if (bus.halt)                sel = SEL_HOLD;
    else if (bus.rti && exc_active)   sel = SEL_RTI;
    else if (bus.jr_valid)            sel = bus.stall ? SEL_HOLD : SEL_JR;
    else if (bus.br_valid)            sel = SEL_BR;
    else if (bus.stall)               sel = SEL_HOLD;
  end

  always_comb begin
    case (sel)
      SEL_HOLD: pc_next = pc;
      SEL_INC:  pc_next = pc_inc;
      SEL_BR:   pc_next = (pc + bus.br_off) & MASK;
      SEL_JR:   pc_next = (bus.rs + bus.imm) & MASK;
      SEL_EXC:  pc_next = AW'(EXC_VEC) & MASK;
      SEL_RTI:  pc_next = epc & MASK;
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= AW'(RESET_PC);
      epc        <= '0;
      halted     <= 1'b0;
      exc_active <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state == RUN) begin
        if (bus.siic && !exc_active) begin
          epc        <= pc_inc;
          exc_active <= 1'b1;
        end else if (bus.halt) begin
          state  <= HALT;
          halted <= 1'b1;
        end else if (bus.rti && exc_active) begin
          exc_active <= 1'b0;
        end
      end
    end
  end

  assign bus.pc         = pc;
  assign bus.pc_next    = pc_next;
  assign bus.pc_inc     = pc_inc;
  assign bus.epc        = epc;
  assign bus.halted     = halted;
  assign bus.exc_active = exc_active;

`ifdef PC_RAS_EN
  logic advance;
  assign advance = (sel != SEL_HOLD);

  pc_seq_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.call && advance),
    .pop   (bus.ret && advance),
    .data  (pc_inc),
    .top   (bus.ras_top),
    .valid (bus.ras_valid)
  );
`else
  logic unused_ras;
  assign unused_ras    = bus.call ^ bus.ret;
  assign bus.ras_top   = '0;
  assign bus.ras_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized
// redirect traffic checked against a behavioural model of the sequencer.
module tb_pc_seq_unit;
  localparam int AW        = 16;
  localparam int INC       = 2;
  localparam int RESET_PC  = 0;
  localparam int EXC_VEC   = 2;
  localparam int RAS_DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_seq_unit_if #(.AW(AW)) bus ();

  pc_seq_unit #(
    .AW(AW), .INC(INC), .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_pc, m_epc;
  bit m_halted, m_exc;
  int m_ras[$];

  function automatic int wrap(int v);
    return v & 'hFFFF;
  endfunction

  function automatic int algn(int v);
    return v & 'hFFFF & ~(INC - 1);
  endfunction

  function automatic int ras_exp();
    return (m_ras.size() > 0) ? m_ras[$] : 0;
  endfunction

  task automatic idle();
    bus.stall = 0; bus.br_valid = 0; bus.br_off = '0; bus.jr_valid = 0;
    bus.rs = '0; bus.imm = '0; bus.siic = 0; bus.rti = 0; bus.halt = 0;
    bus.call = 0; bus.ret = 0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_epc = 0; m_halted = 0; m_exc = 0;
    m_ras.delete();
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 0;
    #2;
    rst = 1;
    model_reset();
  endtask

  // Advance one clock: sample pc_next, apply the sequencer rules to the model.
  task automatic tick(output int exp_next, output logic [AW-1:0] seen_next);
    int nxt, inc_v;
    bit moved;
    #1;
    seen_next = bus.pc_next;
    inc_v = wrap(m_pc + INC);
    nxt = m_pc;
    moved = 0;
    if (!m_halted) begin
      if (bus.siic && !m_exc) begin
        nxt = algn(EXC_VEC); moved = 1; m_epc = inc_v; m_exc = 1;
      end else if (bus.halt) begin
        m_halted = 1;
      end else if (bus.rti && m_exc) begin
        nxt = algn(m_epc); moved = 1; m_exc = 0;
      end else if (bus.jr_valid) begin
        if (!bus.stall) begin nxt = algn(int'(bus.rs) + int'(bus.imm)); moved = 1; end
      end else if (bus.br_valid) begin
        nxt = algn(m_pc + int'(bus.br_off)); moved = 1;
      end else if (!bus.stall) begin
        nxt = inc_v; moved = 1;
      end
    end
    if (RAS_EN && moved) begin
      if (bus.call && bus.ret && m_ras.size() > 0) m_ras[m_ras.size() - 1] = inc_v;
      else if (bus.call) begin
        if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(inc_v);
      end else if (bus.ret && m_ras.size() > 0) void'(m_ras.pop_back());
    end
    m_pc = nxt;
    exp_next = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int e;
    logic [AW-1:0] s;
    idle();
    #1 rst = 0;
    #3;
    n_cmp++;
    if ({bus.pc, bus.epc, bus.halted, bus.exc_active, bus.ras_valid} !== {16'h0000, 16'h0000, 3'b000}) begin
      n_bad++; $display("FAIL reset_power_on: got pc=%h epc=%h h=%b x=%b rv=%b", bus.pc, bus.epc, bus.halted, bus.exc_active, bus.ras_valid);
    end
    @(negedge clk);
    rst = 1;
    model_reset();
    bus.siic = 1;
    tick(e, s);
    bus.siic = 0;
    repeat (31) tick(e, s);
    n_cmp++;
    if ({bus.pc, bus.epc, bus.exc_active} !== {16'h0040, 16'h0002, 1'b1}) begin
      n_bad++; $display("FAIL reset_prerun: got pc=%h epc=%h x=%b want 0040 0002 1", bus.pc, bus.epc, bus.exc_active);
    end
    #2 rst = 0;
    #1;
    n_cmp++;
    if ({bus.pc, bus.epc, bus.halted, bus.exc_active} !== {16'h0000, 16'h0000, 2'b00}) begin
      n_bad++; $display("FAIL reset_async: got pc=%h epc=%h h=%b x=%b want 0000 0000 0 0", bus.pc, bus.epc, bus.halted, bus.exc_active);
    end
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_sequence();
    int e;
    logic [AW-1:0] s;
    logic [AW-1:0] want [6];
    want = '{16'h0002, 16'h0004, 16'h0006, 16'h0006, 16'h0006, 16'h0002};
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.stall = (i >= 3);
      if (i == 5) begin bus.br_valid = 1; bus.br_off = 16'hFFFC; end
      tick(e, s);
      n_cmp++;
      if (s !== 16'(e)) begin n_bad++; $display("FAIL seq_next[%0d]: got %h want %h", i, s, 16'(e)); end
      n_cmp++;
      if (bus.pc !== want[i]) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, want[i]); end
    end
  endtask

  task automatic test_exception();
    int e;
    logic [AW-1:0] s;
    logic [2:0] op [5];
    logic [32:0] want [5];
    op   = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    want = '{{16'h0010, 16'h0000, 1'b0}, {16'h0002, 16'h0012, 1'b1}, {16'h0004, 16'h0012, 1'b1},
             {16'h0012, 16'h0012, 1'b0}, {16'h0014, 16'h0012, 1'b0}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (op[i] == 3'd1) begin bus.jr_valid = 1; bus.rs = 16'h0010; end
      bus.siic = (op[i] == 3'd2);
      bus.rti  = (op[i] == 3'd3);
      tick(e, s);
      n_cmp++;
      if ({bus.pc, bus.epc, bus.exc_active} !== want[i]) begin
        n_bad++; $display("FAIL exc[%0d]: got pc=%h epc=%h x=%b want %h", i, bus.pc, bus.epc, bus.exc_active, want[i]);
      end
    end
  endtask

  task automatic test_jump();
    int e;
    logic [AW-1:0] s;
    idle();
    bus.jr_valid = 1; bus.rs = 16'h1001; bus.imm = 16'h0004; bus.stall = 1;
    tick(e, s);
    n_cmp++;
    if (bus.pc !== 16'h0014) begin n_bad++; $display("FAIL jr_stalled: got %h want 0014", bus.pc); end
    bus.stall = 0;
    tick(e, s);
    n_cmp++;
    if (s !== 16'h1004) begin n_bad++; $display("FAIL jr_next: got %h want 1004", s); end
    n_cmp++;
    if ({bus.pc, bus.pc_inc} !== {16'h1004, 16'h1006}) begin
      n_bad++; $display("FAIL jr_pc: got pc=%h inc=%h want 1004 1006", bus.pc, bus.pc_inc);
    end
  endtask

  task automatic test_wrap();
    int e;
    logic [AW-1:0] s;
    idle();
    bus.jr_valid = 1; bus.rs = 16'hFFF0; bus.imm = 16'h000F;
    tick(e, s);
    n_cmp++;
    if ({bus.pc, bus.pc_inc} !== {16'hFFFE, 16'h0000}) begin
      n_bad++; $display("FAIL wrap_jr: got pc=%h inc=%h want FFFE 0000", bus.pc, bus.pc_inc);
    end
    idle();
    tick(e, s);
    n_cmp++;
    if (bus.pc !== 16'h0000) begin n_bad++; $display("FAIL wrap_inc: got %h want 0000", bus.pc); end
    bus.br_valid = 1; bus.br_off = 16'hFFFF;
    tick(e, s);
    n_cmp++;
    if (bus.pc !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_br: got %h want FFFE", bus.pc); end
  endtask

  task automatic test_random();
    int e;
    logic [AW-1:0] s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.stall    = ($urandom_range(0, 2) == 0);
      bus.br_valid = ($urandom_range(0, 4) == 0);
      bus.br_off   = 16'($urandom);
      bus.jr_valid = ($urandom_range(0, 4) == 0);
      bus.rs       = 16'($urandom);
      bus.imm      = 16'($urandom);
      bus.siic     = ($urandom_range(0, 7) == 0);
      bus.rti      = ($urandom_range(0, 5) == 0);
      bus.halt     = 0;
      bus.call     = ($urandom_range(0, 3) == 0);
      bus.ret      = ($urandom_range(0, 3) == 0);
      tick(e, s);
      n_cmp++;
      if (s !== 16'(e)) begin n_bad++; $display("FAIL rnd_next[%0d]: got %h want %h", i, s, 16'(e)); end
      n_cmp++;
      if ({bus.pc, bus.pc_inc, bus.epc, bus.exc_active, bus.halted} !==
          {16'(m_pc), 16'(wrap(m_pc + INC)), 16'(m_epc), m_exc, m_halted}) begin
        n_bad++; $display("FAIL rnd_state[%0d]: got pc=%h inc=%h epc=%h x=%b want pc=%h epc=%h x=%b",
                          i, bus.pc, bus.pc_inc, bus.epc, bus.exc_active, 16'(m_pc), 16'(m_epc), m_exc);
      end
      n_cmp++;
      if ({bus.ras_valid, bus.ras_top} !== {m_ras.size() > 0, 16'(ras_exp())}) begin
        n_bad++; $display("FAIL rnd_ras[%0d]: got v=%b top=%h want v=%b top=%h", i, bus.ras_valid, bus.ras_top, m_ras.size() > 0, 16'(ras_exp()));
      end
    end
  endtask

  task automatic test_ras();
    int e;
    logic [AW-1:0] s;
    logic [1:0] op [16];
    op = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
           2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle();
      bus.call = op[i][0];
      bus.ret  = op[i][1];
      tick(e, s);
      n_cmp++;
      if ({bus.ras_valid, bus.ras_top} !== {m_ras.size() > 0, 16'(ras_exp())}) begin
        n_bad++; $display("FAIL ras[%0d]: got v=%b top=%h want v=%b top=%h", i, bus.ras_valid, bus.ras_top, m_ras.size() > 0, 16'(ras_exp()));
      end
      if (i == 4) begin
        n_cmp++;
        if (bus.ras_top !== (RAS_EN ? 16'h000A : 16'h0000)) begin
          n_bad++; $display("FAIL ras_full_top: got %h want %h", bus.ras_top, RAS_EN ? 16'h000A : 16'h0000);
        end
      end
    end
  endtask

  task automatic test_halt();
    int e;
    logic [AW-1:0] s;
    idle();
    bus.jr_valid = 1; bus.rs = 16'h0020;
    tick(e, s);
    idle();
    bus.halt = 1; bus.br_valid = 1; bus.br_off = 16'h0008;
    tick(e, s);
    n_cmp++;
    if ({bus.pc, bus.halted} !== {16'h0020, 1'b1}) begin
      n_bad++; $display("FAIL halt_enter: got pc=%h h=%b want 0020 1", bus.pc, bus.halted);
    end
    for (int i = 0; i < 6; i++) begin
      bus.siic = 1; bus.halt = ($urandom_range(0, 1) == 1);
      bus.br_valid = ($urandom_range(0, 1) == 1); bus.stall = ($urandom_range(0, 1) == 1);
      tick(e, s);
      n_cmp++;
      if ({s, bus.pc, bus.pc_inc, bus.exc_active, bus.halted} !== {16'h0020, 16'h0020, 16'h0022, 1'b0, 1'b1}) begin
        n_bad++; $display("FAIL halt_hold[%0d]: got next=%h pc=%h inc=%h x=%b h=%b", i, s, bus.pc, bus.pc_inc, bus.exc_active, bus.halted);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_sequence();
    test_exception();
    test_jump();
    test_wrap();
    test_random();
    test_ras();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
